// File: rtl/ultrasonic_echo_detector_if.sv
// Bus bundle between the echo detector and its controller / time-of-flight consumer.
interface ultrasonic_echo_detector_if #(
  parameter int unsigned CNT_W = 10
);
  logic             enable;
  logic             sig_in;
  logic             detected;
  logic             period_valid;
  logic [CNT_W-1:0] half_period;
  logic [15:0]      edge_count;

  // Controller side: drives enable and the raw comparator, observes results.
  modport master (
    output enable,
    output sig_in,
    input  detected,
    input  period_valid,
    input  half_period,
    input  edge_count
  );

  // Detector side.
  modport slave (
    input  enable,
    input  sig_in,
    output detected,
    output period_valid,
    output half_period,
    output edge_count
  );
endinterface

// File: rtl/ultrasonic_echo_detector.sv
// Ultrasonic echo detector: synchronises the receiver comparator, measures
// edge-to-edge half-periods and locks onto a carrier near NOMINAL_HALF cycles.
module ultrasonic_echo_detector #(
  parameter int unsigned NOMINAL_HALF = 337,
  parameter int unsigned TOL          = 16,
  parameter int unsigned LOCK_CYCLES  = 4,
  parameter int unsigned TIMEOUT      = 1023,
  parameter int unsigned CNT_W        = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ultrasonic_echo_detector_if.slave   bus
);

  localparam int unsigned TOL_LO = (NOMINAL_HALF > TOL) ? (NOMINAL_HALF - TOL) : 0;
  localparam int unsigned TOL_HI = NOMINAL_HALF + TOL;
  localparam int unsigned VW     = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned EC_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_TRACK  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q, hist_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [VW-1:0]     valid_q, valid_d;
  logic              detected_q, detected_d;
  logic              pv_q, pv_d;
  logic [CNT_W-1:0]  hp_q, hp_d;
  logic [EC_W-1:0]   ec_q, ec_d;

  logic              edge_c;
  logic              in_tol_c;
  logic              timeout_c;
  logic [VW-1:0]     valid_inc_c;
  logic              lock_hit_c;

  assign edge_c      = sync2_q ^ hist_q;
  assign in_tol_c    = (32'(cnt_q) >= TOL_LO) && (32'(cnt_q) <= TOL_HI);
  assign timeout_c   = (cnt_q == CNT_W'(TIMEOUT));
  assign valid_inc_c = valid_q + VW'(1);
  assign lock_hit_c  = (32'(valid_inc_c) == LOCK_CYCLES);

  // Two-flop synchroniser plus history flop for either-polarity edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= bus.sig_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an edge takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_SEARCH;
        S_SEARCH: if (edge_c) state_d = S_TRACK;
        S_TRACK: begin
          if (edge_c) begin
            if (in_tol_c && lock_hit_c) state_d = S_LOCKED;
          end else if (timeout_c) begin
            state_d = S_SEARCH;
          end
        end
        S_LOCKED: begin
          if (edge_c) begin
            if (!in_tol_c) state_d = S_TRACK;
          end else if (timeout_c) begin
            state_d = S_SEARCH;
          end
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values; detected follows the state being entered.
  always_comb begin
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    pv_d       = 1'b0;
    hp_d       = hp_q;
    ec_d       = ec_q;
    detected_d = (state_d == S_LOCKED);

    if (!bus.enable || (state_q == S_IDLE)) begin
      cnt_d   = '0;
      valid_d = '0;
      ec_d    = '0;
    end else begin
      if (edge_c) begin
        cnt_d = CNT_W'(1);
        if (ec_q != {EC_W{1'b1}}) ec_d = ec_q + EC_W'(1);
      end else if (!timeout_c) begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_q)
        S_SEARCH: begin
          if (edge_c) valid_d = '0;
        end
        S_TRACK: begin
          if (edge_c) begin
            pv_d    = 1'b1;
            hp_d    = cnt_q;
            valid_d = in_tol_c ? valid_inc_c : '0;
          end else if (timeout_c) begin
            valid_d = '0;
          end
        end
        S_LOCKED: begin
          if (edge_c) begin
            pv_d = 1'b1;
            hp_d = cnt_q;
            if (!in_tol_c) valid_d = '0;
          end else if (timeout_c) begin
            valid_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      valid_q    <= '0;
      detected_q <= 1'b0;
      pv_q       <= 1'b0;
      hp_q       <= '0;
      ec_q       <= '0;
    end else begin
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      detected_q <= detected_d;
      pv_q       <= pv_d;
      hp_q       <= hp_d;
      ec_q       <= ec_d;
    end
  end

  assign bus.detected     = detected_q;
  assign bus.period_valid = pv_q;
  assign bus.half_period  = hp_q;
  assign bus.edge_count   = ec_q;

endmodule

// File: tb/tb_ultrasonic_echo_detector.sv
// Directed bench for the ultrasonic echo detector: acquisition, tolerance
// boundaries, timeout, enable drop, async reset and edge-to-pulse latency.
module tb_ultrasonic_echo_detector;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  ultrasonic_echo_detector_if #(.CNT_W(10)) bus ();

  ultrasonic_echo_detector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Toggle sig_in n clk edges after the previous toggle and check the result.
  // Entry/exit point: 4 clk edges (+1 unit) after the previous toggle's edge.
  task automatic step(input int n, input string nm, input logic exp_pv,
                      input int exp_hp, input logic exp_det, input int exp_ec);
    repeat (n - 4) @(posedge clk);
    #2 bus.sig_in = ~bus.sig_in;
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_pv"},  32'(bus.period_valid), 32'(exp_pv));
    chk({nm, "_hp"},  32'(bus.half_period),  32'(exp_hp));
    chk({nm, "_det"}, 32'(bus.detected),     32'(exp_det));
    chk({nm, "_ec"},  32'(bus.edge_count),   32'(exp_ec));
    @(posedge clk);
    #1;
    chk({nm, "_pv_off"}, 32'(bus.period_valid), 32'(0));
  endtask

  initial begin
    int lat;
    int d;
    n_chk      = 0;
    n_fail     = 0;
    rst_n      = 1'b1;
    bus.enable = 1'b0;
    bus.sig_in = 1'b0;
    #10 rst_n  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_det", 32'(bus.detected),     32'(0));
    chk("rst_pv",  32'(bus.period_valid), 32'(0));
    chk("rst_hp",  32'(bus.half_period),  32'(0));
    chk("rst_ec",  32'(bus.edge_count),   32'(0));
    #2;
    rst_n      = 1'b1;
    bus.enable = 1'b1;
    @(posedge clk);
    #1;

    // 1: nominal acquisition, lock on the 5th edge
    step(10, "s1e1", 1'b0, 0, 1'b0, 1);
    for (int i = 2; i <= 6; i++)
      step(337, $sformatf("s1e%0d", i), 1'b1, 337, (i >= 5), i);

    // 2: single long half-period breaks lock, then reacquire
    step(360, "s2e7", 1'b1, 360, 1'b0, 7);
    for (int i = 8; i <= 11; i++)
      step(337, $sformatf("s2e%0d", i), 1'b1, 337, (i == 11), i);

    // 3: tolerance boundaries
    step(354, "s3e12", 1'b1, 354, 1'b0, 12);
    for (int i = 13; i <= 16; i++)
      step((i % 2 == 1) ? 321 : 353, $sformatf("s3e%0d", i), 1'b1,
           (i % 2 == 1) ? 321 : 353, (i == 16), i);
    step(320, "s3e17", 1'b1, 320, 1'b0, 17);
    step(321, "s3e18", 1'b1, 321, 1'b0, 18);
    step(353, "s3e19", 1'b1, 353, 1'b0, 19);
    step(321, "s3e20", 1'b1, 321, 1'b0, 20);
    step(354, "s3e21", 1'b1, 354, 1'b0, 21);
    for (int i = 22; i <= 25; i++)
      step(337, $sformatf("s3e%0d", i), 1'b1, 337, (i == 25), i);

    // 4: loss of signal, detected drops exactly 1023 clk after the last pulse
    repeat (1021) @(posedge clk);
    #1;
    chk("s4_pre_timeout_det", 32'(bus.detected), 32'(1));
    chk("s4_pre_timeout_pv",  32'(bus.period_valid), 32'(0));
    @(posedge clk);
    #1;
    chk("s4_timeout_det", 32'(bus.detected), 32'(0));
    step(78, "s4e26", 1'b0, 337, 1'b0, 26);
    for (int i = 27; i <= 30; i++)
      step(337, $sformatf("s4e%0d", i), 1'b1, 337, (i == 30), i);

    // 5: enable dropped for one cycle
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    chk("s5_det", 32'(bus.detected),     32'(0));
    chk("s5_ec",  32'(bus.edge_count),   32'(0));
    chk("s5_hp",  32'(bus.half_period),  32'(337));
    chk("s5_pv",  32'(bus.period_valid), 32'(0));
    bus.enable = 1'b1;
    step(10, "s5e1", 1'b0, 337, 1'b0, 1);
    for (int i = 2; i <= 5; i++)
      step(337, $sformatf("s5e%0d", i), 1'b1, 337, (i == 5), i);

    // 6a: latency from randomly phased sig_in transitions to period_valid
    for (int i = 0; i < 100; i++) begin
      repeat (330) @(posedge clk);
      d = int'($urandom_range(5, 95));
      #(d);
      bus.sig_in = ~bus.sig_in;
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        #1;
      end while (!bus.period_valid && lat < 8);
      chk($sformatf("s6_lat%0d", i), 32'(lat), 32'(3));
    end
    chk("s6_locked_det", 32'(bus.detected),   32'(1));
    chk("s6_locked_ec",  32'(bus.edge_count), 32'(105));

    // 6b: asynchronous reset mid-cycle while locked
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_det", 32'(bus.detected),     32'(0));
    chk("s6_rst_pv",  32'(bus.period_valid), 32'(0));
    chk("s6_rst_hp",  32'(bus.half_period),  32'(0));
    chk("s6_rst_ec",  32'(bus.edge_count),   32'(0));
    bus.sig_in = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(10, "s6e1", 1'b0, 0, 1'b0, 1);
    for (int i = 2; i <= 5; i++)
      step(337, $sformatf("s6e%0d", i), 1'b1, 337, (i == 5), i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ultrasonic_echo_detector.md
Name: ultrasonic_echo_detector

Overview:
- Receive-side counterpart to the 40 kHz transmit square-wave generator (27 MHz clk, toggle every 337 cycles).
- Synchronises the asynchronous comparator output from the ultrasonic receiver and measures the clk-cycle distance between consecutive edges.
- Asserts `detected` once enough consecutive half-periods fall within tolerance of the nominal 337 cycles.
- Feeds the time-of-flight logic.

Parameters:
- NOMINAL_HALF, 337, expected half-period in clk cycles.
- TOL, 16, allowed absolute deviation from NOMINAL_HALF (inclusive).
- LOCK_CYCLES, 4, consecutive in-tolerance half-periods required to assert `detected`.
- TIMEOUT, 1023, cycles without an edge before declaring loss of signal; must be less than or equal to 2^CNT_W-1.
- CNT_W, 10, width of the half-period counter and measurement.

Ports:
- clk  in  1  system clock, 27 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  detector enable; low forces IDLE.
- sig_in  in  1  raw receiver comparator output, asynchronous to clk.
- detected  out  1  high while in LOCKED.
- period_valid  out  1  one-cycle pulse when half_period is updated.
- half_period  out  CNT_W  last measured edge-to-edge distance in clk cycles.
- edge_count  out  16  edges seen since enable rose; saturates at 0xFFFF.

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0, all internal state is cleared, and the FSM is in IDLE. Synchronizer flops are also 0.
- Input path: 2-FF synchronizer followed by a history flop. An edge is either polarity, detected as sync_q XOR hist_q.
- Edge latency: fixed at 3 clk from the first clk edge that samples a new sig_in level to period_valid high. The bench checks that this latency is constant.
- Half-period counter:
  - Counts clk cycles since the last edge and saturates at TIMEOUT.
  - On an edge, the measured value is the exact number of clk cycles between the two edges. A generator toggling every 337 cycles must read 337.
  - The counter restarts on every edge.
- In tolerance means NOMINAL_HALF-TOL <= measurement <= NOMINAL_HALF+TOL. The comparison is unsigned, with no wrap.
- FSM states: IDLE, SEARCH, TRACK, LOCKED.
- IDLE:
  - enable low → stay in IDLE. counters are 0, edge_count is 0, detected is 0.
  - half_period holds its last value.
  - enable high → SEARCH on the next cycle.
- SEARCH:
  - First edge → TRACK with valid_cnt=0. No measurement is made and period_valid stays 0; this edge only starts the counter.
  - edge_count increments.
- TRACK, on each edge:
  - half_period updates and period_valid pulses.
  - In tolerance → valid_cnt++. If valid_cnt reaches LOCK_CYCLES → LOCKED, and detected goes high in the same cycle the FSM enters LOCKED.
  - Out of tolerance → valid_cnt=0 and stay in TRACK.
- LOCKED, on each edge:
  - half_period updates and period_valid pulses.
  - Out of tolerance → TRACK with valid_cnt=0; detected falls on the same transition.
- Timeout, from TRACK or LOCKED: the counter reaching TIMEOUT with no edge → SEARCH, valid_cnt=0, detected=0. The timeout fires once.
- Edge and timeout in the same cycle: the edge wins. The measurement equals TIMEOUT, is out of tolerance, and the FSM takes the out-of-tolerance path.
- enable deasserted in any state → IDLE on the next clk, with outputs as defined for IDLE.
- rst_n asserted mid-lock → immediate clear. After release, the FSM starts in IDLE and needs a full reacquisition of LOCK_CYCLES+1 edges.
- edge_count saturates and does not wrap.
- half_period is only written on edges in TRACK or LOCKED.

Test Plan:
1. Reset released, enable=1, sig_in is a 337-cycle half-period square wave → period_valid pulses each edge with half_period=337. detected rises at the 5th edge (1 reference edge + 4 valid) and stays high; edge_count increments per edge.
2. Locked, then a single half-period of 360 cycles → half_period=360 and detected falls on that edge. Then 337-cycle half-periods → detected re-rises after 4 more valid edges.
3. Boundary tolerance, half-periods alternating 321 and 353 → lock achieved. A single 320 or 354 → valid_cnt clears and no lock on that edge.
4. Locked, then sig_in held static for 1100 cycles → exactly 1023 cycles after the last edge the FSM is in SEARCH and detected=0. The next edge produces no period_valid.
5. Locked, enable dropped for 1 cycle → detected=0 and edge_count=0 the next cycle, half_period unchanged. Re-enable → reacquires per scenario 1.
6. rst_n pulsed low asynchronously mid-cycle while locked → all outputs 0 immediately with no clk edge required. Latency from sig_in transition to period_valid is measured at 3 clk across 100 randomly phased edges.
